uart_resp_tx: RTL and testbench

UART_RESP_TX -- requirements
Module: uart_resp_tx

---
 rtl/uart_pkg.sv | 29 ++
 rtl/resp_fifo.sv | 57 +++++
 rtl/uart_resp_tx.sv | 111 +++++++++++
 tb/tb_uart_resp_tx.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: response-TX FSM states, framing constants, checksum helper.
// No logic of its own; imported by the response transmitter and the UART core.
// Frame layouts are raw (4 data bytes) or header + 4 data bytes + XOR checksum.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_DONE = 2'd2
    } tx_state_e;

    localparam logic [7:0] HDR_BASE      = 8'hA0;
    localparam int         FRAME_LEN_RAW = 4;
    localparam int         FRAME_LEN_HDR = 6;

    typedef struct packed {
        logic [2:0]  tag;
        logic [31:0] data;
    } resp_t;

    function automatic logic [7:0] hdr_byte(input logic [2:0] tag);
        return HDR_BASE | {5'b0, tag};
    endfunction

    function automatic logic [7:0] frame_checksum(input logic [7:0] hdr, input logic [31:0] d);
        return hdr ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Generic synchronous FIFO with registered storage and occupancy counter.
// Latency: a push becomes visible at pop_dat the cycle after it is written.
// Backpressure: push_rdy drops when full; push and pop may complete in the same cycle.
module resp_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n_sync,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign push_rdy = (count != CW'(DEPTH));
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_resp_tx.sv
// Serialises queued register responses into UART byte frames, optional header/checksum.
// Latency: word pushed into an idle, empty block in cycle N launches its first byte in N+2.
// Backpressure: req_ready = FIFO not full; each byte waits for tx_done, aborts on timeout.
module uart_resp_tx
    import uart_pkg::*;
#(
    parameter int W_REG       = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst_n_sync,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W_REG-1:0] req_data,
    input  logic [2:0]       req_tag,
    input  logic             cfg_hdr_en,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_done,
    output logic             busy,
    output logic             frame_done,
    output logic             tx_err
);
    localparam int FW = 3 + W_REG;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    tx_state_e     state;
    logic          fifo_vld;
    logic [FW-1:0] fifo_dat;
    resp_t         head;
    logic [39:0]   shreg;
    logic [2:0]    rem;
    logic [TW-1:0] tmo_cnt;
    logic          pop;

    resp_fifo #(.W(FW), .DEPTH(2)) u_fifo (
        .clk       (clk),
        .rst_n_sync(rst_n_sync),
        .push_vld  (req_valid),
        .push_rdy  (req_ready),
        .push_dat  ({req_tag, req_data}),
        .pop_vld   (fifo_vld),
        .pop_rdy   (pop),
        .pop_dat   (fifo_dat)
    );

    assign head = fifo_dat;
    assign pop  = (state == ST_IDLE) && fifo_vld;
    assign busy = (state != ST_IDLE) || fifo_vld;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state      <= ST_IDLE;
            tx_byte    <= 8'h00;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            tx_err     <= 1'b0;
            shreg      <= '0;
            rem        <= '0;
            tmo_cnt    <= '0;
        end else begin
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
            tx_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // First byte goes straight to tx_byte; shreg holds the rest, LSB first.
                    if (fifo_vld) begin
                        state    <= ST_SEND;
                        tx_valid <= 1'b1;
                        if (cfg_hdr_en) begin
                            tx_byte <= hdr_byte(head.tag);
                            shreg   <= {frame_checksum(hdr_byte(head.tag), head.data), head.data};
                            rem     <= 3'(FRAME_LEN_HDR - 1);
                        end else begin
                            tx_byte <= head.data[7:0];
                            shreg   <= {16'h0000, head.data[31:8]};
                            rem     <= 3'(FRAME_LEN_RAW - 1);
                        end
                    end
                end
                ST_SEND: begin
                    state   <= ST_WAIT_DONE;
                    tmo_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (rem != '0) begin
                            state    <= ST_SEND;
                            tx_valid <= 1'b1;
                            tx_byte  <= shreg[7:0];
                            shreg    <= {8'h00, shreg[39:8]};
                            rem      <= rem - 3'd1;
                        end else begin
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        tx_err <= 1'b1;
                        rem    <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_resp_tx.sv
// Scoreboard bench for uart_resp_tx: a frame-level reference model fills expected queues,
// a monitor pops and compares on every tx_valid / frame_done / tx_err.
module tb_uart_resp_tx;

    logic        clk;
    logic        rst_n_sync;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [2:0]  req_tag;
    logic        cfg_hdr_en;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_done;
    logic        busy;
    logic        frame_done;
    logic        tx_err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] exp_bytes[$];
    bit         exp_evt[$];   // 0 = frame_done expected, 1 = tx_err expected

    int resp_count = 0;
    int resp_limit = -1;
    int spur_seq   = 0;
    bit resp_hold  = 0;

    uart_resp_tx #(.W_REG(32), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rst_n_sync(rst_n_sync),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .cfg_hdr_en(cfg_hdr_en),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_done   (tx_done),
        .busy      (busy),
        .frame_done(frame_done),
        .tx_err    (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        n_chk++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference model: frame bytes from the framing rules; keep>0 models a timeout abort
    // after that many bytes have been launched.
    task automatic model_push(input logic [31:0] d, input logic [2:0] t, input logic h, input int keep);
        logic [7:0] fr[$];
        logic [7:0] c;
        c = 8'h00;
        if (h) fr.push_back(8'hA0 | {5'b0, t});
        for (int i = 0; i < 4; i++) fr.push_back(d[8*i +: 8]);
        if (h) begin
            foreach (fr[i]) c ^= fr[i];
            fr.push_back(c);
        end
        if (keep > 0) begin
            for (int i = 0; i < keep; i++) exp_bytes.push_back(fr[i]);
            exp_evt.push_back(1'b1);
        end else begin
            foreach (fr[i]) exp_bytes.push_back(fr[i]);
            exp_evt.push_back(1'b0);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic [2:0] t, input int keep);
        int guard;
        guard     = 0;
        req_valid = 1'b1;
        req_data  = d;
        req_tag   = t;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 500) begin
                fail("push_accept", "req_ready never rose");
                req_valid = 1'b0;
                return;
            end
        end
        model_push(d, t, cfg_hdr_en, keep);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || exp_bytes.size() != 0 || exp_evt.size() != 0) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3000) fail("wait_idle", $sformatf("busy=%0d pending_bytes=%0d", busy, exp_bytes.size()));
    endtask

    // UART core stand-in: answers each launched byte after 1..4 cycles, subject to limit/hold.
    initial begin
        int cnt;
        int spur_seen;
        cnt       = 0;
        spur_seen = 0;
        tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (spur_seq != spur_seen) begin
                spur_seen = spur_seq;
                if (cnt == 0) tx_done = 1'b1;
            end else if (cnt > 0) begin
                if (!(resp_hold && cnt == 1)) begin
                    cnt--;
                    if (cnt == 0) tx_done = 1'b1;
                end
            end else if (tx_valid && rst_n_sync) begin
                if (resp_limit < 0 || resp_count < resp_limit) begin
                    resp_count++;
                    cnt = $urandom_range(1, 4);
                end
            end
        end
    end

    // Monitor
    initial begin
        int outstanding;
        bit e;
        outstanding = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n_sync) begin
                outstanding = 0;
            end else begin
                if (tx_done || tx_err) outstanding = 0;
                if (tx_valid) begin
                    chk("launch_before_done", outstanding, 0);
                    outstanding = 1;
                    if (exp_bytes.size() == 0) fail("tx_byte", $sformatf("unexpected byte %02h", tx_byte));
                    else chk("tx_byte", tx_byte, exp_bytes.pop_front());
                end
                if (frame_done) begin
                    if (exp_evt.size() == 0) fail("frame_end", "unexpected frame_done");
                    else begin
                        e = exp_evt.pop_front();
                        chk("frame_end_is_tx_err", 0, e);
                    end
                end
                if (tx_err) begin
                    if (exp_evt.size() == 0) fail("frame_end", "unexpected tx_err");
                    else begin
                        e = exp_evt.pop_front();
                        chk("frame_end_is_tx_err", 1, e);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int guard;
        int n;
        rst_n_sync = 1'b0;
        req_valid  = 1'b0;
        req_data   = '0;
        req_tag    = '0;
        cfg_hdr_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n_sync = 1'b1;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 8'h00);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tx_err", tx_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);

        // Raw frame plus launch latency: push edge ends cycle N, tx_valid in N+2.
        req_valid = 1'b1; req_data = 32'h12345678; req_tag = 3'd3;
        model_push(32'h12345678, 3'd3, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("latency_n1_tx_valid", tx_valid, 0);
        @(negedge clk);
        chk("latency_n2_tx_valid", tx_valid, 1);
        wait_idle();

        // Header frame: A3,78,56,34,12 and XOR checksum 8'hAB.
        cfg_hdr_en = 1'b1;
        push_word(32'h12345678, 3'd3, 0);
        wait_idle();

        // Header enable flipped after the frame has started.
        push_word(32'hA5C30F96, 3'd5, 0);
        guard = 0;
        while (!tx_valid && guard < 100) begin @(negedge clk); guard++; end
        cfg_hdr_en = 1'b0;
        wait_idle();

        // Three back-to-back words with tx_done held off: queue fills.
        resp_hold = 1'b1;
        push_word(32'h11111111, 3'd1, 0);
        push_word(32'h22222222, 3'd2, 0);
        push_word(32'h33333333, 3'd3, 0);
        chk("full_req_ready", req_ready, 0);
        chk("full_busy", busy, 1);
        repeat (2) @(negedge clk);
        resp_hold = 1'b0;
        wait_idle();

        // Timeout: second byte of the first frame is never acknowledged.
        resp_limit = resp_count + 1;
        push_word(32'hCAFEF00D, 3'd0, 2);
        push_word(32'h0BADC0DE, 3'd4, 0);
        guard = 0;
        while (!tx_err && guard < 200) begin @(negedge clk); guard++; end
        chk("timeout_tx_err", tx_err, 1);
        resp_limit = -1;
        wait_idle();

        // Reset while the third byte is in flight, with a second word queued.
        push_word(32'h55AA33CC, 3'd6, 0);
        push_word(32'h99887766, 3'd7, 0);
        seen = 0; guard = 0;
        while (seen < 3 && guard < 300) begin
            if (tx_valid) seen++;
            if (seen < 3) begin @(negedge clk); guard++; end
        end
        chk("third_byte_seen", seen, 3);
        #1;
        rst_n_sync = 1'b0;
        exp_bytes.delete();
        exp_evt.delete();
        @(negedge clk);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_byte", tx_byte, 8'h00);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_tx_err", tx_err, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n_sync = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        repeat (40) @(negedge clk);
        chk("post_reset_idle", busy, 0);

        // Spurious tx_done while idle, then a frame that must pace on its own tx_done pulses.
        spur_seq++;
        repeat (3) @(negedge clk);
        chk("spurious_idle", busy, 0);
        push_word(32'hDEADBEEF, 3'd2, 0);
        wait_idle();

        // Randomised batches, header setting fixed per batch.
        for (int b = 0; b < 25; b++) begin
            cfg_hdr_en = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                push_word($urandom, 3'($urandom_range(0, 7)), 0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle();
        end

        chk("scoreboard_drained", exp_bytes.size() + exp_evt.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
